// File: rtl/seq_pkg.sv
// Shared definitions for the serial sequence driver: FSM state encoding and
// a width helper that never returns a zero-width result.
package seq_pkg;

    // Two-state controller: waiting for a request, or shifting a frame out.
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    // Bits needed to index 'value' items, never less than one bit.
    function automatic int clog2_min1(input int value);
        return (value <= 2) ? 1 : $clog2(value);
    endfunction

endpackage : seq_pkg

// File: rtl/bit_tick_gen.sv
// Bit-period timer for seq_serializer. While 'run' is high it counts
// 0..DIV-1 and wraps; while 'run' is low it sits at zero, so every bit
// period begins from a clean count. 'tick_first' marks count 0 and
// 'tick_last' marks count DIV-1. With DIV=1 both strobes are constant high.
module bit_tick_gen
    import seq_pkg::*;
#(
    parameter int DIV = 1
) (
    input  logic CLK,
    input  logic RST,
    input  logic run,
    output logic tick_first,
    output logic tick_last
);

    generate
        if (DIV == 1) begin : g_div1
            // Every cycle is both the first and the last cycle of its bit.
            assign tick_first = 1'b1;
            assign tick_last  = 1'b1;

            // Clock, reset and enable have no effect when no counter exists.
            logic unused_inputs;
            assign unused_inputs = ^{CLK, RST, run};
        end else begin : g_divn
            localparam int CNT_W = clog2_min1(DIV);
            localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);
            localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

            logic [CNT_W-1:0] divcnt_q;
            logic [CNT_W-1:0] divcnt_d;

            // Next count: hold at zero when stopped, wrap after DIV-1.
            always_comb begin
                if (!run) begin
                    divcnt_d = '0;
                end else if (divcnt_q == CNT_LAST) begin
                    divcnt_d = '0;
                end else begin
                    divcnt_d = divcnt_q + CNT_ONE;
                end
            end

            // Counter register with synchronous reset.
            always_ff @(posedge CLK) begin
                if (RST) begin
                    divcnt_q <= '0;
                end else begin
                    divcnt_q <= divcnt_d;
                end
            end

            assign tick_first = (divcnt_q == '0);
            assign tick_last  = (divcnt_q == CNT_LAST);
        end
    endgenerate

endmodule : bit_tick_gen

// File: rtl/seq_serializer.sv
// Serial sequence driver. Captures a WIDTH-bit word on START and shifts it
// out on X, one bit per DIV clocks, LSB-first or MSB-first. LEDS is a one-hot
// marker of the bit on the line. BUSY covers the frame, BIT_VALID strobes on
// the first cycle of each bit, and DONE pulses once at each frame end. With
// REPEAT high at a frame end, a fresh DATA word is loaded and shifting
// continues with no gap.
//
// Build option: define SEQ_SERIALIZER_PARITY_EN to append an even-parity
// slot of DIV cycles after the last data bit (LEDS=0 during that slot).
//
// All outputs are decoded from registers only; no input reaches an output
// combinationally.
module seq_serializer
    import seq_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int DIV       = 1,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic             REPEAT,
    input  logic [WIDTH-1:0] DATA,
    output logic             X,
    output logic [WIDTH-1:0] LEDS,
    output logic             BUSY,
    output logic             BIT_VALID,
    output logic             DONE
);

    localparam int IDX_W = clog2_min1(WIDTH);

    // Index of the first and last data bit on the line for this bit order.
    localparam logic [IDX_W-1:0] FIRST_IDX = MSB_FIRST ? IDX_W'(WIDTH - 1) : IDX_W'(0);
    localparam logic [IDX_W-1:0] LAST_IDX  = MSB_FIRST ? IDX_W'(0) : IDX_W'(WIDTH - 1);
    localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1);

    state_t           state_q,  state_d;
    logic [WIDTH-1:0] shadow_q, shadow_d;
    logic [IDX_W-1:0] idx_q,    idx_d;
    logic             done_q,   done_d;
`ifdef SEQ_SERIALIZER_PARITY_EN
    // High while the parity slot follows the last data bit.
    logic             par_q,    par_d;
`endif

    logic             tick_first;
    logic             tick_last;
    logic [IDX_W-1:0] next_idx;

    // Bit-period timer runs only while a frame is on the line; leaving
    // SHIFT (or reset) returns it to zero for the next frame.
    bit_tick_gen #(
        .DIV (DIV)
    ) u_bit_tick_gen (
        .CLK        (CLK),
        .RST        (RST),
        .run        (state_q == ST_SHIFT),
        .tick_first (tick_first),
        .tick_last  (tick_last)
    );

    assign next_idx = MSB_FIRST ? (idx_q - IDX_ONE) : (idx_q + IDX_ONE);

    // Next-state logic: accept a request in IDLE, step bits in SHIFT, and
    // either reload or stop at the end of each frame.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path
        // leaves it unassigned; an unassigned path would infer a latch.
        state_d  = state_q;
        shadow_d = shadow_q;
        idx_d    = idx_q;
        done_d   = 1'b0;
`ifdef SEQ_SERIALIZER_PARITY_EN
        par_d    = par_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (START) begin
                    shadow_d = DATA;
                    idx_d    = FIRST_IDX;
                    state_d  = ST_SHIFT;
`ifdef SEQ_SERIALIZER_PARITY_EN
                    par_d    = 1'b0;
`endif
                end
            end

            ST_SHIFT: begin
                if (tick_last) begin
                    if (idx_q != LAST_IDX) begin
                        idx_d = next_idx;
`ifdef SEQ_SERIALIZER_PARITY_EN
                    end else if (!par_q) begin
                        // Last data bit finished: the parity slot follows.
                        par_d = 1'b1;
`endif
                    end else begin
                        // Frame complete. Reloading here keeps idx inside
                        // [0, WIDTH-1] instead of letting it wrap.
                        done_d = 1'b1;
`ifdef SEQ_SERIALIZER_PARITY_EN
                        par_d  = 1'b0;
`endif
                        if (REPEAT) begin
                            shadow_d = DATA;
                            idx_d    = FIRST_IDX;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers with synchronous reset; reset mid-frame drops the
    // frame and suppresses its DONE pulse.
    always_ff @(posedge CLK) begin
        // NOTE: non-blocking assignments make every flop sample the values
        // from before the edge, independent of statement order.
        if (RST) begin
            state_q  <= ST_IDLE;
            shadow_q <= '0;
            idx_q    <= '0;
            done_q   <= 1'b0;
`ifdef SEQ_SERIALIZER_PARITY_EN
            par_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            shadow_q <= shadow_d;
            idx_q    <= idx_d;
            done_q   <= done_d;
`ifdef SEQ_SERIALIZER_PARITY_EN
            par_q    <= par_d;
`endif
        end
    end

    // Output decode from registered state only.
    always_comb begin
        X         = 1'b0;
        LEDS      = '0;
        BUSY      = 1'b0;
        BIT_VALID = 1'b0;
        if (state_q == ST_SHIFT) begin
            BUSY      = 1'b1;
            BIT_VALID = tick_first;
            X         = shadow_q[idx_q];
            LEDS      = WIDTH'(1) << idx_q;
`ifdef SEQ_SERIALIZER_PARITY_EN
            if (par_q) begin
                X    = ^shadow_q;
                LEDS = '0;
            end
`endif
        end
    end

    assign DONE = done_q;

endmodule : seq_serializer
